// File: rtl/debounce_scan.sv
// debounce_scan: one debounce counter shared round-robin among NBTN buttons.
// Each button keeps a 2-bit state; the counter is lent to one unconfirmed change at a time.
module debounce_scan_btn (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  input  logic grant_i,
  input  logic done_i,
  output logic req_o,
  output logic lvl_o
);
  typedef enum logic [1:0] {WAIT_LOW, WAIT_HIGH, CNT_HIGH, CNT_LOW} st_e;
  st_e st_q, st_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) st_q <= WAIT_LOW;
    else       st_q <= st_d;
  end

  // Accept-then-confirm: the level flips at grant, the window only holds it.
  always_comb begin
    st_d = st_q;
    case (st_q)
      WAIT_LOW:  if (grant_i) st_d = CNT_HIGH;
      WAIT_HIGH: if (grant_i) st_d = CNT_LOW;
      CNT_HIGH:  if (done_i)  st_d = WAIT_HIGH;
      CNT_LOW:   if (done_i)  st_d = WAIT_LOW;
      default:   st_d = WAIT_LOW;
    endcase
  end

  assign req_o = ((st_q == WAIT_LOW) && btn_i) || ((st_q == WAIT_HIGH) && !btn_i);
  assign lvl_o = (st_q == CNT_HIGH) || (st_q == WAIT_HIGH);
endmodule

module debounce_scan #(
  parameter int NBTN      = 4,
  parameter int MAX_COUNT = 4095,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1),
  parameter int PTR_W     = $clog2(NBTN)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tp_i,
  input  logic [NBTN-1:0]  btn_i,
  output logic [NBTN-1:0]  btn_o,
  output logic [NBTN-1:0]  press_o,
  output logic [NBTN-1:0]  release_o,
  output logic             busy_o,
  output logic [PTR_W-1:0] owner_o
);
  typedef enum logic {IDLE, OWNED} eng_e;

  eng_e             eng_q, eng_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [NBTN-1:0]  prev_q, prev_d, press_q, press_d, rel_q, rel_d;
  logic [NBTN-1:0]  req, grant, done, lvl;
  logic [PTR_W-1:0] win, cand;
  logic             found, grant_vld, complete;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    debounce_scan_btn u_btn (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .btn_i   (btn_i[i]),
      .grant_i (grant[i]),
      .done_i  (done[i]),
      .req_o   (req[i]),
      .lvl_o   (lvl[i])
    );
  end

  // Round-robin: scan from last_grant+1, wrapping, first requester wins.
  always_comb begin
    win   = owner_q;
    cand  = owner_q;
    found = 1'b0;
    for (int k = 0; k < NBTN; k++) begin
      cand = (cand == PTR_W'(NBTN - 1)) ? '0 : cand + PTR_W'(1);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    eng_d     = eng_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    grant_vld = (eng_q == IDLE) && (|req);
    complete  = (eng_q == OWNED) && (cnt_q == CNT_W'(MAX_COUNT));
    if (grant_vld) begin
      eng_d   = OWNED;
      cnt_d   = '0;
      owner_d = win;
    end else if (complete) begin
      // completion wins over a coincident tick, so the count never passes MAX_COUNT
      eng_d = IDLE;
      cnt_d = '0;
    end else if ((eng_q == OWNED) && tp_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign grant = grant_vld ? (NBTN'(1) << win)     : '0;
  assign done  = complete  ? (NBTN'(1) << owner_q) : '0;

  always_comb begin
    prev_d  = lvl;
    press_d = lvl & ~prev_q;
    rel_d   = ~lvl & prev_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      eng_q   <= IDLE;
      cnt_q   <= '0;
      owner_q <= PTR_W'(NBTN - 1);
      prev_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      eng_q   <= eng_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      prev_q  <= prev_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign btn_o     = lvl;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign busy_o    = (eng_q == OWNED);
  assign owner_o   = owner_q;
endmodule

// File: tb/tb_debounce_scan.sv
// Bench for debounce_scan: vector table plus corner sequences, grant-order scoreboard
// and a negedge monitor checking window length, edge pulses and level stability.
module tb_debounce_scan;
  localparam int NBTN = 4;
  localparam int MAXC = 3;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       tp_i  = 1'b0;
  logic [3:0] btn_i = 4'b0000;
  logic [3:0] btn_o, press_o, release_o;
  logic       busy_o;
  logic [1:0] owner_o;

  debounce_scan #(.NBTN(NBTN), .MAX_COUNT(MAXC)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .tp_i      (tp_i),
    .btn_i     (btn_i),
    .btn_o     (btn_o),
    .press_o   (press_o),
    .release_o (release_o),
    .busy_o    (busy_o),
    .owner_o   (owner_o)
  );

  always #5 clk_i = ~clk_i;

  int tcnt = 0;
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      tcnt++;
      tp_i = ((tcnt % 4) == 0);
    end
  end

  int n_vec  = 0;
  int n_miss = 0;
  int exp_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples at negedge, far from the active edge.
  logic [3:0] b1 = '0, b2 = '0;
  logic       busy1 = 1'b0, req_pend = 1'b0;
  int         win_ticks = 0, gap = 0;
  int         press_cnt[4], rel_cnt[4];

  always @(negedge clk_i) begin
    if (rst_i) begin
      chk("rst_btn_o",   int'(btn_o), 0);
      chk("rst_busy",    int'(busy_o), 0);
      chk("rst_owner",   int'(owner_o), NBTN - 1);
      chk("rst_press",   int'(press_o), 0);
      chk("rst_release", int'(release_o), 0);
      b1 = '0; b2 = '0; busy1 = 1'b0; req_pend = 1'b0;
      win_ticks = 0; gap = 0;
    end else begin
      gap++;
      if (req_pend) chk("grant_latency", int'(busy_o), 1);
      if (busy_o && !busy1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_grant: got owner %0d, want no grant at %0t", owner_o, $time);
        end else begin
          chk("grant_owner", int'(owner_o), exp_q.pop_front());
        end
        chk("grant_flip", int'(btn_o ^ b1), 1 << owner_o);
        win_ticks = 0;
      end else begin
        chk("btn_o_steady", int'(btn_o ^ b1), 0);
      end
      if (!busy_o && busy1) begin
        chk("win_ticks", win_ticks, MAXC);
        chk("win_tail", gap, 2);
      end
      if (busy_o && tp_i) begin
        win_ticks++;
        gap = 0;
      end
      chk("press",   int'(press_o),   int'(b1 & ~b2));
      chk("release", int'(release_o), int'(~b1 & b2));
      for (int i = 0; i < 4; i++) begin
        press_cnt[i] += int'(press_o[i]);
        rel_cnt[i]   += int'(release_o[i]);
      end
      req_pend = !busy_o && (btn_i != btn_o);
      b2 = b1; b1 = btn_o; busy1 = busy_o;
    end
  end

  task automatic settle(input string nm);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_i); #1;
      if (!busy_o && btn_o == btn_i) return;
    end
    n_vec++; n_miss++;
    $display("FAIL %s_settle: got busy %0d btn_o %b, want idle with btn_o %b", nm, busy_o, btn_o, btn_i);
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    for (int c = 0; c < 100; c++) begin
      if (busy_o == lvl) return;
      @(negedge clk_i); #1;
    end
    n_vec++; n_miss++;
    $display("FAIL %s_wait: got busy %0d, want %0d", nm, busy_o, lvl);
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 4; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; end
  endtask

  typedef struct {
    logic [3:0] btn;
    int         ng;
    int         g[4];
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{4'b0101, 2, '{0, 2, 0, 0}, 4'b0101};
    tbl[1] = '{4'b0000, 2, '{0, 2, 0, 0}, 4'b0000};
    tbl[2] = '{4'b0001, 1, '{0, 0, 0, 0}, 4'b0001};
    tbl[3] = '{4'b1110, 4, '{1, 2, 3, 0}, 4'b1110};
    tbl[4] = '{4'b0000, 3, '{1, 2, 3, 0}, 4'b0000};
    tbl[5] = '{4'b1010, 2, '{1, 3, 0, 0}, 4'b1010};
    tbl[6] = '{4'b0101, 4, '{0, 1, 2, 3}, 4'b0101};
    tbl[7] = '{4'b0000, 2, '{0, 2, 0, 0}, 4'b0000};
    clr_cnt();

    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1 rst_i = 1'b0;

    for (int v = 0; v < 8; v++) begin
      for (int j = 0; j < tbl[v].ng; j++) exp_q.push_back(tbl[v].g[j]);
      btn_i = tbl[v].btn;
      settle("table");
      chk("table_btn_o", int'(btn_o), int'(tbl[v].exp));
      chk("table_queue", exp_q.size(), 0);
    end

    // Bounce on button 0 inside its own window
    clr_cnt();
    exp_q.push_back(0);
    btn_i = 4'b0001;
    wait_busy(1'b1, "bounce");
    repeat (6) begin
      btn_i[0] = ~btn_i[0];
      @(negedge clk_i); #1;
    end
    settle("bounce");
    chk("bounce_btn_o", int'(btn_o), 4'b0001);
    chk("bounce_press", press_cnt[0], 1);
    chk("bounce_release", rel_cnt[0], 0);
    exp_q.push_back(0);
    btn_i = 4'b0000;
    settle("bounce_off");
    chk("bounce_off_btn_o", int'(btn_o), 0);

    // Short pulse on button 1 while button 0 owns the counter
    clr_cnt();
    exp_q.push_back(0);
    btn_i = 4'b0001;
    wait_busy(1'b1, "glitch");
    btn_i = 4'b0011;
    repeat (2) begin @(negedge clk_i); #1; end
    btn_i = 4'b0001;
    settle("glitch");
    chk("glitch_btn_o", int'(btn_o), 4'b0001);
    chk("glitch_press1", press_cnt[1], 0);
    chk("glitch_queue", exp_q.size(), 0);
    exp_q.push_back(0);
    btn_i = 4'b0000;
    settle("glitch_off");

    // Reset while button 2 is mid-window at count 2
    exp_q.push_back(2);
    btn_i = 4'b0100;
    wait_busy(1'b1, "rstmid");
    for (int c = 0; c < 100 && win_ticks < 2; c++) begin @(negedge clk_i); #1; end
    chk("rstmid_ticks", win_ticks, 2);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    btn_i = 4'b0101;
    #1;
    chk("rstmid_btn_o",   int'(btn_o), 0);
    chk("rstmid_busy",    int'(busy_o), 0);
    chk("rstmid_owner",   int'(owner_o), 3);
    chk("rstmid_press",   int'(press_o), 0);
    chk("rstmid_release", int'(release_o), 0);
    exp_q.push_back(0);
    exp_q.push_back(2);
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1'b0;
    settle("rstmid");
    chk("rstmid_after_btn_o", int'(btn_o), 4'b0101);
    chk("rstmid_queue", exp_q.size(), 0);

    // Buttons 1 and 3 keep re-requesting; grants must alternate
    rst_i = 1'b1;
    btn_i = 4'b1010;
    foreach (tbl[0].g[k]) begin end
    for (int k = 0; k < 7; k++) exp_q.push_back((k % 2 == 0) ? 1 : 3);
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      wait_busy(1'b0, "rr_idle");
      wait_busy(1'b1, "rr_grant");
      if (k < 5) begin
        if (k % 2 == 0) btn_i[1] = ~btn_i[1];
        else            btn_i[3] = ~btn_i[3];
      end
    end
    settle("rr");
    chk("rr_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish before 200000");
    $fatal(1);
  end
endmodule
